// File: rtl/sram_if_pkg.sv
// Shared encodings for the CPU data-SRAM responder: access sizes, FSM states,
// the pending-request record and the LFSR constants used by the random-delay build.
package sram_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Lane enables for a store; size 3 behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lo;
            SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// In-order pending-request queue for data_sram_responder; head is the oldest entry.
module sram_req_fifo
    import sram_if_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  req_t                         push_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output req_t                         head
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

    req_t          slots [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage carries no reset; the pointers and count alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push)
            slots[wr_ptr] <= push_data;
    end

    assign count = count_q;
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/data_sram_responder.sv
// CPU data port responder over a local 32-bit word array with fixed-latency, in-order replies.
// Define SRAM_RESP_RAND_DELAY_EN to add an LFSR-driven 0..3 cycle jitter to every countdown load.
module data_sram_responder
    import sram_if_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int MEM_AW  = 10,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int CNT_W = 5;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  load_val;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    req_t              head;
    req_t              push_data;
    logic [MEM_AW-1:0] head_idx;
    logic [3:0]        head_be;
    logic [31:0]       mem [2**MEM_AW];

    assign data_addr_ok = data_req && !fifo_full && !rst;
    assign accept       = data_req && data_addr_ok;
    assign push_data    = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    sram_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (data_data_ok),
        .push_data (push_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

`ifdef SRAM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign load_val = CNT_W'(LATENCY - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A zero load skips WAIT so that LATENCY=1 still answers on the next cycle.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = load_val;
                    state_d = (load_val == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (fifo_count != CW'(1) || accept) begin
                    cnt_d   = load_val;
                    state_d = (load_val == '0) ? ST_RESP : ST_WAIT;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_data_ok = (state_q == ST_RESP) && !fifo_empty && !rst;
    assign head_idx     = head.addr[MEM_AW+1:2];
    assign head_be      = byte_en(head.size, head.addr[1:0]);

    always_ff @(posedge clk) begin
        if (data_data_ok && head.wr) begin
            for (int i = 0; i < 4; i++)
                if (head_be[i])
                    mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
        end
    end

    // Reads see the array before this cycle's commit, i.e. every earlier RESP write.
    assign data_rdata = (data_data_ok && !head.wr) ? mem[head_idx] : '0;

    wire unused_head_hi = &{1'b0, head.addr[31:MEM_AW+2]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder (LATENCY=2); SRAM_RESP_RAND_DELAY_EN adds a random scoreboard run.
module tb_data_sram_responder;
    import sram_if_pkg::*;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    resp_t resp_q[$];

    data_sram_responder #(.LATENCY(LATENCY), .MEM_AW(10), .QDEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (data_data_ok)
            resp_q.push_back('{cyc: cyc, data: data_rdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef SRAM_RESP_RAND_DELAY_EN
        check(tag, 32'(lat >= LATENCY && lat <= LATENCY + 3), 32'd1);
`else
        check(tag, 32'(lat), 32'(LATENCY));
`endif
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int acc, output int stalls);
        bit done;
        done   = 1'b0;
        acc    = -1;
        stalls = 0;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = sz;
        data_addr  = a;
        data_wdata = wd;
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge clk);
            if (data_addr_ok) begin
                acc  = cyc;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        data_req = 1'b0;
        if (!done)
            check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string tag, output int rc, output logic [31:0] rd);
        resp_t r;
        rc = -1;
        rd = '0;
        for (int w = 0; w < 64 && resp_q.size() == 0; w++)
            @(negedge clk);
        if (resp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            r  = resp_q.pop_front();
            rc = r.cyc;
            rd = r.data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        int          ac;
        int          st;
        int          rc;
        logic [31:0] rd;
        send(wr, sz, a, wd, ac, st);
        wait_resp(tag, rc, rd);
        check_lat({tag, "_lat"}, rc - ac);
        check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        int          a1, a2, a3, s;
        int          r1, r2, r3;
        logic [31:0] d1, d2, d3;

        rst        = 1'b1;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = SZ_WORD;
        data_addr  = '0;
        data_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        check("rst_data_ok", 32'(data_data_ok), 32'd0);
        check("rst_rdata", data_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check("idle_addr_ok", 32'(data_addr_ok), 32'd0);
        @(posedge clk);
        #1;

        // Single write then read, one response pulse each
        txn("wr10", 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, 32'h0);
        txn("rd10", 1'b0, SZ_WORD, 32'h10, 32'h0, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        #1;
        check("single_pulse", 32'(resp_q.size()), 32'd0);

        // Three back-to-back reads against a two-deep queue
        send(1'b0, SZ_WORD, 32'h10, 32'h0, a1, s);
        send(1'b0, SZ_WORD, 32'h10, 32'h0, a2, s);
        send(1'b0, SZ_WORD, 32'h10, 32'h0, a3, s);
        check("b2b_acc2", 32'(a2 - a1), 32'd1);
        check("b2b_stall3", 32'(s), 32'd1);
        check("b2b_acc3", 32'(a3 - a1), 32'd3);
        wait_resp("b2b_r1", r1, d1);
        wait_resp("b2b_r2", r2, d2);
        wait_resp("b2b_r3", r3, d3);
`ifndef SRAM_RESP_RAND_DELAY_EN
        check("b2b_resp1", 32'(r1 - a1), 32'd2);
        check("b2b_resp2", 32'(r2 - a1), 32'd4);
        check("b2b_resp3", 32'(r3 - a1), 32'd6);
`endif
        check("b2b_order", 32'(r1 < r2 && r2 < r3), 32'd1);
        check("b2b_data", d1 & d2 & d3, 32'hDEADBEEF);

        // Lane merging
        txn("w20", 1'b1, SZ_WORD, 32'h20, 32'h11223344, 32'h0);
        txn("wb21", 1'b1, SZ_BYTE, 32'h21, 32'h0000AA00, 32'h0);
        txn("rd20b", 1'b0, SZ_WORD, 32'h20, 32'h0, 32'h1122AA44);
        txn("w20z", 1'b1, SZ_WORD, 32'h20, 32'h0, 32'h0);
        txn("wh23", 1'b1, SZ_HALF, 32'h23, 32'hBEEFBEEF, 32'h0);
        txn("rd20h", 1'b0, SZ_WORD, 32'h20, 32'h0, 32'hBEEF0000);
        txn("wh21", 1'b1, SZ_HALF, 32'h21, 32'h12345678, 32'h0);
        txn("rd20l", 1'b0, SZ_WORD, 32'h20, 32'h0, 32'hBEEF5678);
        txn("ws3", 1'b1, 2'd3, 32'h42, 32'hCAFEF00D, 32'h0);
        txn("rd40", 1'b0, SZ_BYTE, 32'h43, 32'h0, 32'hCAFEF00D);

        // Reset one cycle after accepting a write: no late response, no commit
        send(1'b1, SZ_WORD, 32'h10, 32'h55555555, a1, s);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_resp", 32'(resp_q.size()), 32'd0);
        send(1'b0, SZ_WORD, 32'h10, 32'h0, a1, s);
        check("post_rst_stall", 32'(s), 32'd0);
        wait_resp("post_rst", r1, d1);
        check_lat("post_rst_lat", r1 - a1);
        check("post_rst_data", d1, 32'hDEADBEEF);

`ifdef SRAM_RESP_RAND_DELAY_EN
        begin
            logic [31:0] mdl [16];
            for (int i = 0; i < 16; i++) begin
                mdl[i] = 32'h01010101 * 32'(i + 1);
                txn("rnd_init", 1'b1, SZ_WORD, 32'h100 + 32'(4 * i), mdl[i], 32'h0);
            end
            for (int k = 0; k < 200; k++) begin
                logic        wr;
                logic [1:0]  sz, lo;
                logic [3:0]  wi, be;
                logic [31:0] wd, exp;
                wr = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                lo = 2'($urandom_range(0, 3));
                wi = 4'($urandom_range(0, 15));
                wd = $urandom();
                exp = wr ? 32'h0 : mdl[wi];
                txn("rnd", wr, sz, 32'h100 + {26'h0, wi, lo}, wd, exp);
                if (wr) begin
                    if (sz == 2'd0)      be = 4'b0001 << lo;
                    else if (sz == 2'd1) be = lo[1] ? 4'b1100 : 4'b0011;
                    else                 be = 4'b1111;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mdl[wi][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from accept or pop to response; legal range 1..15.
REQ-002 SHALL have parameter MEM_AW, default 10: word-address width of the local array (1024 x 32b).
REQ-003 SHALL have parameter QDEPTH, default 2: pending-request queue depth.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 data_req  in  1  CPU request valid.
REQ-008 data_wr  in  1  1 = write, 0 = read.
REQ-009 data_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 data_addr  in  32  byte address; bits [MEM_AW+1:2] index the array.
REQ-011 data_wdata  in  32  write data, lane-aligned.
REQ-012 data_addr_ok  out  1  request accepted this cycle.
REQ-013 data_data_ok  out  1  one-cycle response pulse.
REQ-014 data_rdata  out  32  full read word, valid only while data_ok is high.

Function
REQ-015 SHALL drive data_addr_ok = data_req && (queue count < QDEPTH), combinationally; accept means req && addr_ok.
REQ-016 SHALL push wr, size, addr and wdata into the in-order queue on accept; a pop in the same cycle does not free a slot for that same cycle.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP.
- IDLE: queue empty.
- WAIT: head countdown running.
- RESP: data_ok high for one cycle, head popped.
- From RESP: go to WAIT if the queue is still non-empty, else IDLE.
REQ-018 SHALL load the countdown with LATENCY-1 on accept into an empty queue and on each pop with entries remaining; RESP is entered when the count reaches 0.
REQ-019 Timing consequences of REQ-018:
- An isolated request accepted at cycle T responds at T+LATENCY.
- A queued request responds LATENCY cycles after the previous response.
REQ-020 SHALL commit writes to the array in their RESP cycle, using byte enables from size and addr[1:0]:
- byte: lane addr[1:0].
- half: lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
- word: all four lanes; addr[1:0] is ignored.
REQ-021 SHALL return for reads the whole word at the head address, reflecting every write whose RESP cycle preceded it; data_rdata is 0 for writes and whenever data_ok is low.
REQ-022 SHALL never return responses out of order or drop an accepted request.
REQ-023 SHALL ignore data_req when it is low; request fields are don't-care when not accepted.

Reset
REQ-024 SHALL, while rst is high, force data_addr_ok = 0, data_data_ok = 0, data_rdata = 0, queue empty, FSM to IDLE, countdown = 0.
REQ-025 SHALL discard in-flight requests on rst mid-operation, with no late data_ok after reset.
REQ-026 SHALL leave array contents unchanged by reset; no write commits during rst.

Configuration
REQ-027 SHALL, with SRAM_RESP_RAND_DELAY_EN defined:
- Run an 8-bit Fibonacci LFSR (taps 8, 6, 5, 4), seeded 8'hA5 on reset, stepping every cycle.
- Add lfsr[1:0] (0..3) to each countdown load.
REQ-028 SHALL, without SRAM_RESP_RAND_DELAY_EN, use a fixed latency exactly as in REQ-018, with no LFSR logic present.

Structure
REQ-029 SHALL place size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings and the LFSR seed/taps constants in shared package sram_if_pkg.
REQ-030 SHALL implement the pending queue as sub-module sram_req_fifo (parameter QDEPTH; push, pop, full, empty, count, head).

Verification (LATENCY = 2, macro off)
REQ-031 Read addr 0x10 after preloading 0xDEADBEEF, accepted at cycle 5 -> data_ok at cycle 7 only; rdata = 0xDEADBEEF.
REQ-032 Three back-to-back reads accepted at 5 and 6 -> addr_ok low at cycle 7 (full); responses at cycles 7 and 9; third request accepted at cycle 8.
REQ-033 Word-write 0x11223344 @0x20, then byte-write 0xAA with addr 0x21, then read 0x20 -> read returns 0x1122AA44.
REQ-034 Half-write 0xBEEF with addr 0x23 onto word 0 -> word = 0xBEEF0000.
REQ-035 rst asserted one cycle after accept -> no data_ok for ≥5 cycles; addr_ok = 1 on the first post-reset req.
REQ-036 Macro on, 200 random requests -> every latency between LATENCY and LATENCY+3; order preserved; scoreboard match.
